// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch
// Description : Program counter and instruction fetch stage in front of a
//               ROM with a 1-cycle registered read. Hands instructions to
//               decode over a valid/ready handshake, accepts jumps on the
//               handshake and stops on a HALT opcode.
//               Optional macro INSTR_COUNT_EN adds a saturating 8-bit count
//               of completed handshakes (port instr_count).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch #(
    parameter int                ADDR_W      = 4,
    parameter int                DATA_W      = 8,
    parameter logic [3:0]        HALT_OPCODE = 4'hF,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jmp_en,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
`ifdef INSTR_COUNT_EN
    ,
    output logic [7:0]        instr_count
`endif
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_PC_ONE = ADDR_W'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_instr;
    logic                r_valid;
    logic                r_halted;

    logic                w_handshake;
    logic                w_is_halt;

    // instr_valid is high exactly in HOLD, so HOLD alone qualifies the handshake.
    assign w_handshake = (r_state == ST_HOLD) && instr_ready;
    assign w_is_halt   = (r_instr[DATA_W-1 -: 4] == HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_ISSUE;
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_instr <= rom_data;
                    r_valid <= 1'b1;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (w_handshake) begin
                        r_valid <= 1'b0;
                        // A HALT instruction leaves pc untouched and ignores any jump.
                        if (w_is_halt) begin
                            r_halted <= 1'b1;
                            r_state  <= ST_HALT;
                        end else begin
                            r_pc    <= jmp_en ? jmp_addr : (r_pc + c_PC_ONE);
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_ISSUE;
                end
            endcase
        end
    end

`ifdef INSTR_COUNT_EN
    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 8'h00;
        end else if (w_handshake && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'h01;
        end
    end

    assign instr_count = r_count;
`endif

    assign rom_addr    = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// Scoreboard bench for pc_fetch: directed scenarios followed by random
// ready/jump/reset traffic against a transaction-level fetch model.
module tb_pc_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       jmp_en;
    logic [3:0] jmp_addr;
    logic [3:0] pc;
    logic       halted;
`ifdef INSTR_COUNT_EN
    logic [7:0] instr_count;
`endif

    pc_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jmp_en      (jmp_en),
        .jmp_addr    (jmp_addr),
        .pc          (pc),
        .halted      (halted)
`ifdef INSTR_COUNT_EN
        ,
        .instr_count (instr_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_val(input logic [3:0] a);
        return (a == 4'd3) ? 8'hF3 : (8'h10 + {4'h0, a});
    endfunction

    // ROM: 1-cycle registered read
    always @(posedge clk) rom_data <= rom_val(rom_addr);

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } item_t;

    item_t q[$];
    int    vectors = 0;
    int    errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // Every fetch becomes visible two cycles after it starts; each accepted
    // instruction starts the next fetch at the following cycle.
    int         cyc      = 0;
    int         m_next   = 0;
    bit         started  = 0;
    bit         m_after_rst = 0;
    bit         m_halted = 0;
    logic [3:0] m_pc     = '0;
    int         m_count  = 0;

    always @(posedge clk) begin
        bit mv;
        mv = started && !m_halted && (cyc >= m_next);
        cyc++;
        if (rst) begin
            started     = 1;
            m_after_rst = 1;
            m_pc        = 4'd0;
            m_halted    = 0;
            m_count     = 0;
            q.delete();
            q.push_back('{addr: 4'd0, data: rom_val(4'd0)});
            m_next      = cyc + 2;
        end else begin
            m_after_rst = 0;
            if (mv && instr_ready) begin
                if (m_count < 255) m_count++;
                if (rom_val(m_pc)[7:4] == 4'hF) begin
                    m_halted = 1;
                end else begin
                    m_pc   = jmp_en ? jmp_addr : 4'((m_pc + 4'd1) % 16);
                    q.push_back('{addr: m_pc, data: rom_val(m_pc)});
                    m_next = cyc + 2;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    bit    prev_valid = 0;
    bit    have_cur   = 0;
    item_t cur;

    always @(negedge clk) begin
        if (started) begin
            chk("instr_valid", 32'(instr_valid), 32'(!m_halted && (cyc >= m_next)));
            chk("halted", 32'(halted), 32'(m_halted));
            chk("pc", 32'(pc), 32'(m_pc));
            chk("rom_addr", 32'(rom_addr), 32'(m_pc));
`ifdef INSTR_COUNT_EN
            chk("instr_count", 32'(instr_count), 32'(m_count));
`endif
            if (m_after_rst) chk("reset_instr", 32'(instr), 32'h0);
            if (instr_valid === 1'b1 && !prev_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_delivery", 32'(instr), 32'hFFFF_FFFF);
                    have_cur = 0;
                end else begin
                    cur      = q.pop_front();
                    have_cur = 1;
                end
            end
            if (instr_valid === 1'b1 && have_cur) begin
                chk("instr_data", 32'(instr), 32'(cur.data));
                chk("instr_pc", 32'(pc), 32'(cur.addr));
            end
            prev_valid = (instr_valid === 1'b1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_valid();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) return;
        end
        chk("wait_valid_timeout", 32'(instr_valid), 32'h1);
    endtask

    initial begin
        rst = 1'b1; instr_ready = 1'b0; jmp_en = 1'b0; jmp_addr = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // stream, then backpressure on the third instruction
        instr_ready = 1'b1;
        wait_valid();
        wait_valid();
        @(negedge clk);
        instr_ready = 1'b0;
        wait_valid();
        repeat (5) @(negedge clk);
        // jump to A on the handshake
        instr_ready = 1'b1; jmp_en = 1'b1; jmp_addr = 4'hA;
        @(negedge clk);
        instr_ready = 1'b0; jmp_en = 1'b0;
        wait_valid();
        // jump requests without ready are ignored
        jmp_en = 1'b1; jmp_addr = 4'h5;
        repeat (4) @(negedge clk);
        // jump to E, then stream across the wrap and into the HALT at 3
        instr_ready = 1'b1; jmp_addr = 4'hE;
        @(negedge clk);
        jmp_en = 1'b0;
        repeat (50) @(negedge clk);
        // restart, then reset in the middle of HOLD
        rst = 1'b1; instr_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wait_valid();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst         = ($urandom_range(0, 199) == 0) || (halted && ($urandom_range(0, 7) == 0));
            instr_ready = ($urandom_range(0, 2) != 0);
            jmp_en      = ($urandom_range(0, 3) == 0);
            jmp_addr    = 4'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; instr_ready = 1'b0; jmp_en = 1'b0;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
